apb_event_scheduler: RTL and testbench

Collects single-cycle event pulses from up to four sources into per-source saturating pending counters. Arbitrates among sources with pending events and issues one write command per event to the downstream APB master engine over a valid/ready command interface. Sits between the event producers and the APB master. Owns all queuing and fairness so the master only sequences bus phases.

---
 rtl/apb_event_pkg.sv | 22 ++
 rtl/apb_event_scheduler_if.sv | 24 ++
 rtl/apb_event_counter.sv | 51 +++++
 rtl/apb_event_scheduler.sv | 140 ++++++++++++++
 tb/tb_apb_event_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_event_pkg.sv
// Shared types and constants for the APB event scheduler: FSM states, per-source
// target addresses and command data-word field positions.
package apb_event_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StIssue
  } state_e;

  localparam logic [31:0] EVENT_ADDR [4] = '{
    32'hABBA_0000,
    32'hBAFF_0000,
    32'hCAFE_0000,
    32'hD00D_0000
  };

  localparam int unsigned DATA_IDX_LSB = 24;
  localparam int unsigned DATA_OVF_LSB = 16;
  localparam int unsigned DATA_CNT_LSB = 0;

endpackage

// File: rtl/apb_event_scheduler_if.sv
// Valid/ready write-command channel from the event scheduler to the APB master engine.
// The master modport is the command issuer (scheduler), slave is the consumer.
interface apb_event_scheduler_if;

  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [31:0] cmd_addr_o;
  logic [31:0] cmd_data_o;

  modport master (
    output cmd_valid_o,
    output cmd_addr_o,
    output cmd_data_o,
    input  cmd_ready_i
  );

  modport slave (
    input  cmd_valid_o,
    input  cmd_addr_o,
    input  cmd_data_o,
    output cmd_ready_i
  );

endinterface

// File: rtl/apb_event_counter.sv
// Saturating per-source pending-event counter with sticky overflow flag.
// cnt_nxt_o exposes this cycle's next value so the scheduler can look ahead.
module apb_event_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             ovf_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_sat;
  logic             w_ovf_set;

  assign w_sat     = &r_cnt;
  // A simultaneous grant consumes the new event, so that case never overflows.
  assign w_ovf_set = inc_i && !dec_i && w_sat;

  always_comb begin
    cnt_nxt_o = r_cnt;
    if (inc_i && !dec_i && !w_sat) begin
      cnt_nxt_o = r_cnt + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_nxt_o = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= cnt_nxt_o;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cnt_o = r_cnt;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/apb_event_scheduler.sv
// Event scheduler: counts event pulses per source, arbitrates, and issues one APB write
// command per event. Define APB_EVENT_SCHED_RR_EN for round-robin, else fixed priority.
module apb_event_scheduler
  import apb_event_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     event_i,
  input  logic                   enable_i,
  input  logic                   ovf_clr_i,
  apb_event_scheduler_if.master  cmd,
  output logic [NUM_SRC-1:0]     ovf_o,
  output logic                   busy_o
);

  state_e           r_state;
  logic             r_valid;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;

  logic [CNT_W-1:0] w_cnt     [NUM_SRC];
  logic [CNT_W-1:0] w_cnt_nxt [NUM_SRC];
  logic [NUM_SRC-1:0] w_dec;
  logic             w_any_pend;
  logic             w_found;
  logic [1:0]       w_win;
  logic [CNT_W-1:0] w_win_cnt;
  int unsigned      w_idx;
  logic [31:0]      w_data;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
    assign w_dec[k] = (r_state == StArb) && w_found && (w_win == 2'(k));

    apb_event_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (event_i[k]),
      .dec_i     (w_dec[k]),
      .ovf_clr_i (ovf_clr_i),
      .cnt_o     (w_cnt[k]),
      .cnt_nxt_o (w_cnt_nxt[k]),
      .ovf_o     (ovf_o[k])
    );
  end

`ifdef APB_EVENT_SCHED_RR_EN
  logic [1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 2'(NUM_SRC - 1);
    end else if (r_state == StArb && w_found) begin
      r_ptr <= w_win;
    end
  end
`endif

  // Pending check looks at post-update counts so a fresh event can start ARB next edge.
  always_comb begin
    w_any_pend = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_cnt_nxt[i] != '0) begin
        w_any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_win_cnt = '0;
    w_idx     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef APB_EVENT_SCHED_RR_EN
      w_idx = (32'(r_ptr) + 32'(i) + 1) % NUM_SRC;
`else
      w_idx = 32'(i);
`endif
      if (!w_found && w_cnt[w_idx] != '0) begin
        w_found   = 1'b1;
        w_win     = 2'(w_idx);
        w_win_cnt = w_cnt_nxt[w_idx];
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_data[DATA_IDX_LSB +: 8]  = 8'(w_win);
    w_data[DATA_OVF_LSB +: 8]  = 8'(ovf_o);
    w_data[DATA_CNT_LSB +: 16] = 16'(w_win_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (enable_i && w_any_pend) begin
            r_state <= StArb;
          end
        end
        StArb: begin
          if (w_found) begin
            r_state <= StIssue;
            r_valid <= 1'b1;
            r_addr  <= EVENT_ADDR[w_win];
            r_data  <= w_data;
          end else begin
            r_state <= StIdle;
          end
        end
        StIssue: begin
          if (cmd.cmd_ready_i) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_state <= (enable_i && w_any_pend) ? StArb : StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_valid_o = r_valid;
  assign cmd.cmd_addr_o  = r_addr;
  assign cmd.cmd_data_o  = r_data;
  assign busy_o          = (r_state != StIdle);

endmodule

// File: tb/tb_apb_event_scheduler.sv
// Directed self-checking bench for apb_event_scheduler; fairness expectations follow
// APB_EVENT_SCHED_RR_EN when it is defined for the build.
module tb_apb_event_scheduler;

  logic       clk;
  logic       reset;
  logic [2:0] event_i;
  logic       enable_i;
  logic       ovf_clr_i;
  logic [2:0] ovf_o;
  logic       busy_o;

  int unsigned vec_cnt;
  int unsigned err_cnt;

  logic [31:0] got_addr;
  logic [31:0] got_data;

  localparam logic [31:0] A_ADDR = 32'hABBA_0000;
  localparam logic [31:0] B_ADDR = 32'hBAFF_0000;
  localparam logic [31:0] C_ADDR = 32'hCAFE_0000;

`ifdef APB_EVENT_SCHED_RR_EN
  localparam logic [31:0] FAIR_ADDR [6] = '{A_ADDR, B_ADDR, C_ADDR, A_ADDR, B_ADDR, C_ADDR};
  localparam logic [31:0] FAIR_DATA [6] = '{32'h0000_0001, 32'h0100_0001, 32'h0200_0001,
                                            32'h0000_0000, 32'h0100_0000, 32'h0200_0000};
`else
  localparam logic [31:0] FAIR_ADDR [6] = '{A_ADDR, A_ADDR, B_ADDR, B_ADDR, C_ADDR, C_ADDR};
  localparam logic [31:0] FAIR_DATA [6] = '{32'h0000_0001, 32'h0000_0000, 32'h0100_0001,
                                            32'h0100_0000, 32'h0200_0001, 32'h0200_0000};
`endif

  apb_event_scheduler_if cmd_if ();

  apb_event_scheduler #(
    .NUM_SRC (3),
    .CNT_W   (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .event_i   (event_i),
    .enable_i  (enable_i),
    .ovf_clr_i (ovf_clr_i),
    .cmd       (cmd_if),
    .ovf_o     (ovf_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    event_i   = '0;
    ovf_clr_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for a command with ready already high, captures it, consumes it.
  task automatic get_cmd(output logic [31:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    a   = '0;
    d   = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmd_if.cmd_valid_o) begin
        a   = cmd_if.cmd_addr_o;
        d   = cmd_if.cmd_data_o;
        got = 1'b1;
      end
      tick();
    end
    if (!got) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;

    // Reset with events active
    reset               = 1'b1;
    event_i             = 3'b111;
    enable_i            = 1'b1;
    ovf_clr_i           = 1'b0;
    cmd_if.cmd_ready_i  = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("rst_addr", cmd_if.cmd_addr_o, 32'd0);
    chk("rst_data", cmd_if.cmd_data_o, 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset   = 1'b0;
    event_i = '0;
    repeat (4) tick();
    chk("post_rst_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // Single event on source 1
    event_i = 3'b010;
    tick();
    event_i = '0;
    chk("single_arb_busy", 32'(busy_o), 32'd1);
    chk("single_arb_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    tick();
    chk("single_valid", 32'(cmd_if.cmd_valid_o), 32'd1);
    chk("single_addr", cmd_if.cmd_addr_o, B_ADDR);
    chk("single_data", cmd_if.cmd_data_o, 32'h0100_0000);
    tick();
    chk("single_done_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("single_done_addr", cmd_if.cmd_addr_o, 32'd0);
    chk("single_done_data", cmd_if.cmd_data_o, 32'd0);
    tick();
    chk("single_idle_busy", 32'(busy_o), 32'd0);

    // Fairness: two events on every source
    do_reset();
    enable_i = 1'b0;
    event_i  = 3'b111;
    tick();
    tick();
    event_i  = '0;
    enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      get_cmd(got_addr, got_data);
      chk($sformatf("fair_addr%0d", i), got_addr, FAIR_ADDR[i]);
      chk($sformatf("fair_data%0d", i), got_data, FAIR_DATA[i]);
    end
    chk("fair_idle_busy", 32'(busy_o), 32'd0);

    // Saturation and overflow
    do_reset();
    enable_i = 1'b0;
    event_i  = 3'b001;
    repeat (17) tick();
    event_i = '0;
    chk("sat_ovf", 32'(ovf_o), 32'd1);
    chk("sat_busy", 32'(busy_o), 32'd0);
    event_i   = 3'b001;
    ovf_clr_i = 1'b1;
    tick();
    event_i   = '0;
    chk("sat_set_wins", 32'(ovf_o), 32'd1);
    tick();
    ovf_clr_i = 1'b0;
    chk("sat_clr", 32'(ovf_o), 32'd0);
    enable_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      get_cmd(got_addr, got_data);
      chk($sformatf("sat_addr%0d", i), got_addr, A_ADDR);
      chk($sformatf("sat_data%0d", i), got_data, 32'(14 - i));
    end
    repeat (3) tick();
    chk("sat_end_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("sat_end_busy", 32'(busy_o), 32'd0);

    // Backpressure with a new event on the same source
    do_reset();
    enable_i           = 1'b1;
    cmd_if.cmd_ready_i = 1'b0;
    event_i            = 3'b100;
    tick();
    event_i = '0;
    tick();
    chk("bp_valid", 32'(cmd_if.cmd_valid_o), 32'd1);
    chk("bp_addr", cmd_if.cmd_addr_o, C_ADDR);
    chk("bp_data", cmd_if.cmd_data_o, 32'h0200_0000);
    event_i = 3'b100;
    for (int i = 0; i < 5; i++) begin
      tick();
      event_i = '0;
      chk($sformatf("bp_hold_valid%0d", i), 32'(cmd_if.cmd_valid_o), 32'd1);
      chk($sformatf("bp_hold_addr%0d", i), cmd_if.cmd_addr_o, C_ADDR);
      chk($sformatf("bp_hold_data%0d", i), cmd_if.cmd_data_o, 32'h0200_0000);
    end
    cmd_if.cmd_ready_i = 1'b1;
    tick();
    chk("bp_hs_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("bp_hs_busy", 32'(busy_o), 32'd1);
    get_cmd(got_addr, got_data);
    chk("bp_next_addr", got_addr, C_ADDR);
    chk("bp_next_data", got_data, 32'h0200_0000);
    chk("bp_end_busy", 32'(busy_o), 32'd0);

    // Event on the granted source during its ARB cycle
    do_reset();
    enable_i = 1'b0;
    event_i  = 3'b001;
    tick();
    tick();
    event_i  = '0;
    enable_i = 1'b1;
    tick();
    chk("sim_arb_busy", 32'(busy_o), 32'd1);
    chk("sim_arb_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    event_i = 3'b001;
    tick();
    event_i = '0;
    chk("sim_valid", 32'(cmd_if.cmd_valid_o), 32'd1);
    chk("sim_data", cmd_if.cmd_data_o, 32'h0000_0002);
    tick();
    get_cmd(got_addr, got_data);
    chk("sim_data2", got_data, 32'h0000_0001);
    get_cmd(got_addr, got_data);
    chk("sim_data3", got_data, 32'h0000_0000);
    chk("sim_end_busy", 32'(busy_o), 32'd0);

    // Reset during ISSUE drops the pending command
    cmd_if.cmd_ready_i = 1'b0;
    event_i            = 3'b001;
    tick();
    event_i = '0;
    tick();
    chk("rmid_valid", 32'(cmd_if.cmd_valid_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_drop_valid", 32'(cmd_if.cmd_valid_o), 32'd0);
    chk("rmid_drop_addr", cmd_if.cmd_addr_o, 32'd0);
    chk("rmid_drop_busy", 32'(busy_o), 32'd0);
    cmd_if.cmd_ready_i = 1'b1;
    repeat (3) tick();
    chk("rmid_lost", 32'(cmd_if.cmd_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
